// File: rtl/clk_gen_clk_divider.sv
// Programmable 50%-duty clock divider running on the ring-oscillator loop.
// Ratio updates are requested by load/ack and take effect only at falling boundaries.
module clk_gen_clk_divider #(
  parameter int WIDTH_P = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               en_i,
  input  logic [WIDTH_P-1:0] div_val_i,
  input  logic               div_load_i,
  output logic               div_busy_o,
  output logic               div_ack_o,
  output logic [WIDTH_P-1:0] div_active_o,
  output logic               clk_out_o,
  output logic               tick_o
);

  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH_P-1:0] cnt_q, cnt_d;
  logic [WIDTH_P-1:0] pend_q, pend_d;
  logic [WIDTH_P-1:0] active_q, active_d;
  logic               clk_out_q, clk_out_d;
  logic               tick_q, tick_d;
  logic               ack_q, ack_d;
  logic               busy_q, busy_d;

  logic               capture;
  logic               falling;
  logic               go_off;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= ST_OFF;
      cnt_q     <= '0;
      pend_q    <= '0;
      active_q  <= '0;
      clk_out_q <= 1'b0;
      tick_q    <= 1'b0;
      ack_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pend_q    <= pend_d;
      active_q  <= active_d;
      clk_out_q <= clk_out_d;
      tick_q    <= tick_d;
      ack_q     <= ack_d;
      busy_q    <= busy_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pend_d    = pend_q;
    active_d  = active_q;
    clk_out_d = clk_out_q;
    tick_d    = 1'b0;
    ack_d     = 1'b0;
    busy_d    = busy_q;
    capture   = div_load_i && !busy_q;
    falling   = 1'b0;
    go_off    = 1'b0;

    unique case (state_q)
      ST_OFF: begin
        cnt_d     = '0;
        clk_out_d = 1'b0;
        if (div_load_i) begin
          active_d = div_val_i;
          ack_d    = 1'b1;
        end
        if (en_i) begin
          state_d = ST_RUN;
        end
      end

      ST_RUN, ST_DRAIN: begin
        // A disable during the low phase truncates it; a high phase always completes.
        if (state_q == ST_RUN && !en_i && !clk_out_q) begin
          go_off = 1'b1;
        end else begin
          if (cnt_q == active_q) begin
            cnt_d     = '0;
            clk_out_d = !clk_out_q;
            if (!clk_out_q) begin
              tick_d = 1'b1;
            end else begin
              falling = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end

          if (falling) begin
            if (busy_q) begin
              active_d = pend_q;
              pend_d   = '0;
              busy_d   = 1'b0;
              ack_d    = 1'b1;
            end
            if (en_i) begin
              state_d = ST_RUN;
            end else begin
              go_off = 1'b1;
            end
          end else if (clk_out_q) begin
            state_d = en_i ? ST_RUN : ST_DRAIN;
          end
        end

        // Entering OFF never leaves a request pending: apply it right here.
        if (go_off) begin
          state_d   = ST_OFF;
          cnt_d     = '0;
          clk_out_d = 1'b0;
          if (busy_q) begin
            active_d = pend_q;
            pend_d   = '0;
            busy_d   = 1'b0;
            ack_d    = 1'b1;
          end else if (capture) begin
            active_d = div_val_i;
            ack_d    = 1'b1;
          end
        end else if (capture) begin
          pend_d = div_val_i;
          busy_d = 1'b1;
        end
      end

      default: begin
        state_d   = ST_OFF;
        cnt_d     = '0;
        clk_out_d = 1'b0;
      end
    endcase
  end

  assign clk_out_o    = clk_out_q;
  assign tick_o       = tick_q;
  assign div_ack_o    = ack_q;
  assign div_busy_o   = busy_q;
  assign div_active_o = active_q;

endmodule

// File: tb/tb_clk_gen_clk_divider.sv
// Directed bench for clk_gen_clk_divider: a phase-countdown model checked every
// cycle, plus hand-computed period, latency and handshake expectations.
module tb_clk_gen_clk_divider;

  logic       clk;
  logic       reset_n;
  logic       en_i;
  logic [7:0] div_val_i;
  logic       div_load_i;
  logic       div_busy_o;
  logic       div_ack_o;
  logic [7:0] div_active_o;
  logic       clk_out_o;
  logic       tick_o;

  int cyc     = 0;
  int n_tests = 0;
  int n_fail  = 0;

  clk_gen_clk_divider #(.WIDTH_P(8)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .en_i         (en_i),
    .div_val_i    (div_val_i),
    .div_load_i   (div_load_i),
    .div_busy_o   (div_busy_o),
    .div_ack_o    (div_ack_o),
    .div_active_o (div_active_o),
    .clk_out_o    (clk_out_o),
    .tick_o       (tick_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Model: 'on' plus remaining cycles of the current phase; a disabled output
  // stops at once when low, or at the end of the high phase when high.
  bit       m_valid = 1'b0;
  bit       m_on, m_lvl, m_busy, m_ack, m_tick;
  int       m_rem;
  bit [7:0] m_act, m_pend;

  always @(posedge clk) begin
    bit take, stop;
    if (!reset_n) begin
      m_on = 0; m_lvl = 0; m_busy = 0; m_ack = 0; m_tick = 0;
      m_rem = 0; m_act = 0; m_pend = 0; m_valid = 1'b1;
    end else begin
      m_ack  = 0;
      m_tick = 0;
      if (!m_on) begin
        if (div_load_i) begin m_act = div_val_i; m_ack = 1; end
        if (en_i) begin m_on = 1; m_lvl = 0; m_rem = int'(m_act) + 1; end
      end else begin
        take = div_load_i && !m_busy;
        stop = 0;
        if (!en_i && !m_lvl) begin
          stop = 1;
        end else begin
          m_rem = m_rem - 1;
          if (m_rem == 0) begin
            m_lvl = !m_lvl;
            if (m_lvl) m_tick = 1;
            else begin
              if (m_busy) begin m_act = m_pend; m_busy = 0; m_ack = 1; end
              if (!en_i) stop = 1;
            end
            m_rem = int'(m_act) + 1;
          end
        end
        if (stop) begin
          m_on = 0; m_lvl = 0;
          if (m_busy) begin m_act = m_pend; m_busy = 0; m_ack = 1; end
          else if (take) begin m_act = div_val_i; m_ack = 1; end
        end else if (take) begin
          m_pend = div_val_i; m_busy = 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      n_tests++;
      if (clk_out_o !== m_lvl || tick_o !== m_tick || div_ack_o !== m_ack ||
          div_busy_o !== m_busy || div_active_o !== m_act) begin
        n_fail++;
        $display("FAIL model cyc=%0d got clk=%b tick=%b ack=%b busy=%b act=%0d want clk=%b tick=%b ack=%b busy=%b act=%0d",
                 cyc, clk_out_o, tick_o, div_ack_o, div_busy_o, div_active_o,
                 m_lvl, m_tick, m_ack, m_busy, m_act);
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got %0d want %0d", name, act, exp);
    end else begin
      $display("[TB] ok %s = %0d", name, act);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_level(input logic v);
    int n = 0;
    while (clk_out_o !== v && n < 600) begin
      @(negedge clk);
      n++;
    end
    if (clk_out_o !== v) begin
      n_tests++;
      n_fail++;
      $display("FAIL timeout waiting clk_out_o=%b got %b", v, clk_out_o);
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0; en_i = 1'b0; div_load_i = 1'b0;
    step(2);
    reset_n = 1'b1;
  endtask

  task automatic load_one(input logic [7:0] v);
    div_val_i = v; div_load_i = 1'b1;
    step(1);
    div_load_i = 1'b0;
  endtask

  initial begin
    int k, r0, f0, fm1, f1, f2, highs;
    reset_n = 1'b0; en_i = 1'b0; div_val_i = '0; div_load_i = 1'b0;

    // Reset state
    step(3);
    chk("reset_clk_out", clk_out_o, 0);
    chk("reset_active", div_active_o, 0);
    chk("reset_busy_ack_tick", {div_busy_o, div_ack_o, tick_o}, 0);
    reset_n = 1'b1;

    // D=0 loaded in OFF, then clk/2
    div_val_i = 8'd0; div_load_i = 1'b1;
    step(1);
    div_load_i = 1'b0;
    chk("off_load_ack", div_ack_o, 1);
    chk("off_load_busy", div_busy_o, 0);
    step(1);
    chk("off_ack_one_cycle", div_ack_o, 0);
    en_i = 1'b1;
    wait_level(1'b1);
    r0 = cyc;
    chk("d0_tick_at_rise", tick_o, 1);
    step(1);
    chk("d0_low_next", clk_out_o, 0);
    chk("d0_tick_cleared", tick_o, 0);
    wait_level(1'b1);
    chk("d0_period", cyc - r0, 2);
    step(6);

    // D=3: first rise latency and 4/4 phases
    do_reset();
    load_one(8'd3);
    en_i = 1'b1;
    step(1);
    k = cyc;
    wait_level(1'b1);
    chk("d3_first_rise", cyc - k, 4);
    r0 = cyc;
    wait_level(1'b0);
    chk("d3_high_len", cyc - r0, 4);
    f0 = cyc;
    wait_level(1'b1);
    chk("d3_low_len", cyc - f0, 4);
    step(30);

    // Load D=1 mid-high, second load D=7 while busy is ignored
    wait_level(1'b0);
    wait_level(1'b1);
    load_one(8'd1);
    chk("busy_after_load", div_busy_o, 1);
    load_one(8'd7);
    wait_level(1'b0);
    chk("ack_at_fall", div_ack_o, 1);
    chk("active_at_fall", div_active_o, 1);
    chk("busy_cleared", div_busy_o, 0);
    f0 = cyc;
    wait_level(1'b1);
    chk("new_low_len", cyc - f0, 2);
    step(10);
    chk("second_load_ignored", div_active_o, 1);

    // D=5: drop en one cycle into the high phase, then during a low phase
    do_reset();
    load_one(8'd5);
    en_i = 1'b1;
    wait_level(1'b1);
    r0 = cyc;
    step(1);
    en_i = 1'b0;
    wait_level(1'b0);
    chk("drain_high_len", cyc - r0, 6);
    highs = 0;
    for (int i = 0; i < 12; i++) begin step(1); if (clk_out_o) highs++; end
    chk("off_after_drain_highs", highs, 0);
    en_i = 1'b1;
    wait_level(1'b1);
    wait_level(1'b0);
    en_i = 1'b0;
    highs = 0;
    for (int i = 0; i < 12; i++) begin step(1); if (clk_out_o) highs++; end
    chk("off_from_low_highs", highs, 0);

    // Reset while clk_out_o is high
    en_i = 1'b1;
    wait_level(1'b1);
    reset_n = 1'b0;
    step(1);
    chk("midrun_reset_clk", clk_out_o, 0);
    chk("midrun_reset_active", div_active_o, 0);
    chk("midrun_reset_flags", {div_busy_o, div_ack_o, tick_o}, 0);
    reset_n = 1'b1; en_i = 1'b0;
    step(2);

    // Load on the exact boundary cycle: D=2 -> 4, fall-to-fall 6,6,10
    do_reset();
    load_one(8'd2);
    en_i = 1'b1;
    wait_level(1'b1);
    wait_level(1'b0);
    fm1 = cyc;
    wait_level(1'b1);
    step(2);
    div_val_i = 8'd4; div_load_i = 1'b1;
    step(1);
    div_load_i = 1'b0;
    chk("boundary_is_fall", clk_out_o, 0);
    chk("boundary_no_ack", div_ack_o, 0);
    chk("boundary_busy", div_busy_o, 1);
    f0 = cyc;
    chk("period_a", f0 - fm1, 6);
    wait_level(1'b1);
    wait_level(1'b0);
    f1 = cyc;
    chk("period_b", f1 - f0, 6);
    chk("late_ack", div_ack_o, 1);
    chk("late_active", div_active_o, 4);
    wait_level(1'b1);
    wait_level(1'b0);
    f2 = cyc;
    chk("period_c", f2 - f1, 10);
    step(4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
